sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Two-master Avalon-MM arbiter sharing the single Avalon-MM slave port of the 16-bit off-chip SDRAM controller inside `mysystem` between two fabric masters: M0, the HPS bridge path, and M1, a local FPGA engine. Single-beat transactions only. Pipelined reads with variable latency are supported by tracking outstanding-read ownership in an ID FIFO, so read data returns to the correct master in issue order.

## Interface
- `ADDR_W`, 25, word address width of the SDRAM slave.
- `DATA_W`, 16, data width.
- `MAX_PEND`, 8, maximum outstanding reads (power of 2, ≥2).
- `CLOCK_50` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_address`/`m1_address` in ADDR_W: master addresses.
- `m0_read`, `m0_write`, `m1_read`, `m1_write` in 1: requests; read and write are never both high on one master.
- `m0_writedata`/`m1_writedata` in DATA_W; `m0_byteenable`/`m1_byteenable` in DATA_W/8.
- `m0_waitrequest`/`m1_waitrequest` out 1: low in the cycle that master's command is accepted.
- `m0_readdata`/`m1_readdata` out DATA_W: both driven from `s_readdata`.
- `m0_readdatavalid`/`m1_readdatavalid` out 1.
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable` out: slave command.
- `s_waitrequest` in 1; `s_readdata` in DATA_W; `s_readdatavalid` in 1.
- `pending` out $clog2(MAX_PEND)+1: outstanding read count.
- `err_orphan` out 1: sticky; set when readdatavalid arrives with no reads outstanding.

## Operation
- FSM states:
  - IDLE: no command on the slave.
  - BUSY: the owner's command is muxed to the `s_*` outputs.
- IDLE → BUSY on any eligible request. Owner register loaded in that cycle.
- A read request is eligible only if `pending < MAX_PEND`. A write request is always eligible.
- Tie (both masters eligible): round-robin. The master that was not `last_owner` wins.
  - `last_owner` resets to 1, so M0 wins the first tie.
- BUSY: `s_read`/`s_write` equal the owner's request; the other `s_*` command signals are the owner's inputs.
  - Owner `mX_waitrequest = s_waitrequest`.
  - Non-owner `waitrequest` = 1.
- BUSY → IDLE in the cycle `s_waitrequest` = 0 (acceptance). `last_owner` ← owner.
- Accepted read: push owner ID into the FIFO; `pending` += 1.
- `s_readdatavalid`: pop the FIFO; assert `mX_readdatavalid` for the head ID; `pending` -= 1.
- Push and pop in the same cycle: `pending` is unchanged and FIFO order is preserved.
- `s_readdatavalid` with `pending` = 0: no pop; both `readdatavalid` outputs stay 0; `err_orphan` ← 1.
- Masters hold their commands stable while `waitrequest` = 1 (Avalon rule). The arbiter does not register command payloads.

## Timing
- Reset values:
  - State IDLE.
  - `s_read` = `s_write` = 0; other `s_*` outputs 0.
  - `m*_waitrequest` = 1; `m*_readdatavalid` = 0.
  - `pending` = 0; FIFO empty; `err_orphan` = 0.
- Request seen in IDLE at cycle N → command on the slave at N+1.
- Accepted at cycle k (`s_waitrequest` = 0) → IDLE at k+1 → next command at k+2. One bubble cycle; peak rate is one command per 2 cycles.
- Read return latency through the arbiter: 0 cycles (combinational from `s_readdatavalid`/`s_readdata`).
- `pending` reaches MAX_PEND: new reads stall (waitrequest stays 1) until a pop registers; pending writes still proceed.
- Reset mid-operation: FSM, FIFO, `pending` and `err_orphan` are all cleared. Read data that returns later is orphaned and flagged.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: strict priority; M0 always wins a tie and `last_owner` is unused.
- `ARB_FIXED_PRIO_EN` undefined: round-robin as above.

## Structure
- Package `sdram_arb_pkg` holds:
  - `arb_state_t` enum (IDLE, BUSY).
  - `owner_t` (1 bit).
  - `OWNER_M0` = 0, `OWNER_M1` = 1.
- Sub-module `owner_id_fifo`: synchronous FIFO, depth MAX_PEND, 1-bit wide, with push/pop/empty/full/count.
  - Simultaneous push and pop allowed when full or empty-with-push.

## Test plan
- M0 writes 0x1234 to address 0x10 with `s_waitrequest` low → slave sees write at N+1; `m0_waitrequest` low that cycle; `m1_waitrequest` stays 1.
- M0 and M1 both read continuously, slave latency 3 → grants alternate M0, M1, M0, M1; each `readdatavalid` goes to the matching master in order.
- Slave holds `s_waitrequest` = 1 for 5 cycles → command held stable; `pending` stays 0 until acceptance.
- 8 reads accepted with no returns → 9th read stalls with `pending` = 8. A write from M1 is still granted. One return allows the stalled read next cycle.
- Assert `reset` with 3 reads pending, then inject one `s_readdatavalid` → `pending` = 0, no master `readdatavalid`, `err_orphan` = 1.
- With `ARB_FIXED_PRIO_EN` defined, M0 and M1 both request continuously → M1 is never granted while M0 requests.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdram_arb_pkg : shared types for the two-master SDRAM port arbiter       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package sdram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_M0 = 1'b0;
  localparam owner_t OWNER_M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/owner_id_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | owner_id_fifo : 1-bit synchronous FIFO recording which master owns each  |
// | outstanding read, in issue order.                                        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module owner_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  owner_t           push_id,
  input  logic             pop,
  output owner_t           head_id,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  owner_t           mem_q [DEPTH];
  owner_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head_id = mem_q[rd_ptr_q];
  // A pop frees the slot a simultaneous push needs when full.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: OWNER_M0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdram_port_arbiter : two-master Avalon-MM arbiter for the SDRAM slave,   |
// | with pipelined-read ownership tracking. ARB_FIXED_PRIO_EN selects strict |
// | M0 priority instead of round-robin.                                      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 8,
  localparam int CNT_W   = $clog2(MAX_PEND) + 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic [CNT_W-1:0]    pending,
  output logic                err_orphan
);

  arb_state_t state_q, state_d;
  owner_t     owner_q, owner_d;
  owner_t     winner;
  owner_t     head_id;
  logic       err_orphan_q, err_orphan_d;
  logic       fifo_empty, fifo_full;
  logic       m0_elig, m1_elig;
  logic       accept;

  // Writes never stall on the read-tracking FIFO.
  assign m0_elig = m0_write | (m0_read & ~fifo_full);
  assign m1_elig = m1_write | (m1_read & ~fifo_full);
  assign accept  = (state_q == BUSY) & ~s_waitrequest;

`ifdef ARB_FIXED_PRIO_EN
  assign winner = m0_elig ? OWNER_M0 : OWNER_M1;
`else
  owner_t last_owner_q, last_owner_d;

  always_comb begin
    last_owner_d = accept ? owner_q : last_owner_q;
    winner       = m0_elig ? OWNER_M0 : OWNER_M1;
    if (m0_elig && m1_elig) begin
      winner = (last_owner_q == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) last_owner_q <= OWNER_M1;
    else       last_owner_q <= last_owner_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (m0_elig || m1_elig) begin
          state_d = BUSY;
          owner_d = winner;
        end
      end
      BUSY: begin
        if (!s_waitrequest) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (state_q == BUSY) begin
      if (owner_q == OWNER_M1) begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end else begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
    end
  end

  // Returns with nothing outstanding are dropped and flagged, never routed.
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = s_readdatavalid & ~fifo_empty & (head_id == OWNER_M0);
  assign m1_readdatavalid = s_readdatavalid & ~fifo_empty & (head_id == OWNER_M1);
  assign err_orphan_d     = err_orphan_q | (s_readdatavalid & fifo_empty);
  assign err_orphan       = err_orphan_q;

  owner_id_fifo #(.DEPTH(MAX_PEND)) u_owner_fifo (
    .clk     (CLOCK_50),
    .rst     (reset),
    .push    (accept & s_read),
    .push_id (owner_q),
    .pop     (s_readdatavalid),
    .head_id (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (pending)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_M0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sdram_port_arbiter : directed self-checking bench for the arbiter.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sdram_port_arbiter;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 16;
  localparam int MAX_PEND = 8;
  localparam int CNT_W    = 4;

  logic              CLOCK_50 = 1'b0;
  logic              reset    = 1'b1;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [1:0]        m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [CNT_W-1:0]  pending;
  logic              err_orphan;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .pending(pending), .err_orphan(err_orphan)
  );

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset;
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
    reset = 1;
    tick;
    tick;
    reset = 0;
    #1;
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++;
    if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, s_read, s_write, err_orphan} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 1100000", {m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, s_read, s_write, err_orphan});
    end
    n_checks++;
    if (pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending); end
    n_checks++;
    if ({s_address, s_writedata, s_byteenable} !== 43'd0) begin
      n_fail++; $display("FAIL reset_payload: got %h want 0", {s_address, s_writedata, s_byteenable});
    end
  endtask

  task automatic test_write;
    do_reset;
    m0_write = 1; m0_address = 25'h10; m0_writedata = 16'h1234; m0_byteenable = 2'b11;
    #1;
    n_checks++;
    if ({s_write, m0_waitrequest} !== 2'b01) begin n_fail++; $display("FAIL write_idle: got %b want 01", {s_write, m0_waitrequest}); end
    tick;
    n_checks++;
    if ({s_write, s_read, m0_waitrequest, m1_waitrequest} !== 4'b1001) begin
      n_fail++; $display("FAIL write_grant: got %b want 1001", {s_write, s_read, m0_waitrequest, m1_waitrequest});
    end
    n_checks++;
    if ({s_address, s_writedata, s_byteenable} !== {25'h10, 16'h1234, 2'b11}) begin
      n_fail++; $display("FAIL write_payload: got %h want %h", {s_address, s_writedata, s_byteenable}, {25'h10, 16'h1234, 2'b11});
    end
    tick;
    m0_write = 0;
    #1;
    n_checks++;
    if ({s_write, m0_waitrequest, pending} !== {2'b01, 4'd0}) begin
      n_fail++; $display("FAIL write_done: got %b want 010000", {s_write, m0_waitrequest, pending});
    end
  endtask

  task automatic test_round_robin;
    int   ret_cyc[$];
    logic exp_own[$];
    int   grants = 0;
    int   rets   = 0;
    logic exp_o;
    do_reset;
    m0_read = 1; m0_address = 25'h100;
    m1_read = 1; m1_address = 25'h200;
    for (int cyc = 0; cyc < 30; cyc++) begin
      s_readdatavalid = (ret_cyc.size() > 0) && (ret_cyc[0] == cyc);
      s_readdata      = 16'hA000 + 16'(rets);
      #1;
      if (s_readdatavalid) begin
        exp_o = exp_own.pop_front();
        void'(ret_cyc.pop_front());
        n_checks++;
        if ({m1_readdatavalid, m0_readdatavalid} !== (exp_o ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL rr_return%0d: got %b want owner M%0d", rets, {m1_readdatavalid, m0_readdatavalid}, exp_o);
        end
        rets++;
      end
      if (s_read && !s_waitrequest) begin
`ifdef ARB_FIXED_PRIO_EN
        exp_o = 1'b0;
`else
        exp_o = grants[0];
`endif
        n_checks++;
        if ({m1_waitrequest, m0_waitrequest, s_address} !== {(exp_o ? 2'b01 : 2'b10), (exp_o ? 25'h200 : 25'h100)}) begin
          n_fail++; $display("FAIL rr_grant%0d: got wr=%b addr=%h want owner M%0d", grants, {m1_waitrequest, m0_waitrequest}, s_address, exp_o);
        end
        exp_own.push_back(exp_o);
        ret_cyc.push_back(cyc + 3);
        grants++;
      end
      if (grants == 6 && !s_read) begin
        m0_read = 0; m1_read = 0;
      end
      tick;
    end
    n_checks++;
    if ({grants, rets, 28'(pending)} !== {32'd6, 32'd6, 28'd0}) begin
      n_fail++; $display("FAIL rr_totals: got grants=%0d rets=%0d pending=%0d want 6 6 0", grants, rets, pending);
    end
  endtask

  task automatic test_hold;
    do_reset;
    s_waitrequest = 1;
    m1_read = 1; m1_address = 25'h55;
    tick;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({s_read, m1_waitrequest, m0_waitrequest, pending, s_address} !== {3'b111, 4'd0, 25'h55}) begin
        n_fail++; $display("FAIL hold_cycle%0d: got rd=%b wr=%b p=%0d addr=%h want 1 11 0 55", i, s_read, {m1_waitrequest, m0_waitrequest}, pending, s_address);
      end
      tick;
    end
    s_waitrequest = 0;
    #1;
    n_checks++;
    if ({m1_waitrequest, m0_waitrequest} !== 2'b01) begin n_fail++; $display("FAIL hold_accept: got %b want 01", {m1_waitrequest, m0_waitrequest}); end
    tick;
    m1_read = 0;
    #1;
    n_checks++;
    if ({s_read, pending} !== {1'b0, 4'd1}) begin n_fail++; $display("FAIL hold_pending: got rd=%b p=%0d want 0 1", s_read, pending); end
    s_readdatavalid = 1; s_readdata = 16'hBEEF;
    #1;
    n_checks++;
    if ({m1_readdatavalid, m0_readdatavalid, m1_readdata} !== {2'b10, 16'hBEEF}) begin
      n_fail++; $display("FAIL hold_return: got rdv=%b data=%h want 10 beef", {m1_readdatavalid, m0_readdatavalid}, m1_readdata);
    end
    tick;
    s_readdatavalid = 0;
    #1;
    n_checks++;
    if ({pending, err_orphan} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL hold_drain: got p=%0d orphan=%b want 0 0", pending, err_orphan); end
  endtask

  task automatic test_stall;
    do_reset;
    m0_read = 1; m0_address = 25'h300;
    repeat (16) tick;
    n_checks++;
    if ({pending, s_read} !== {4'd8, 1'b0}) begin n_fail++; $display("FAIL stall_fill: got p=%0d rd=%b want 8 0", pending, s_read); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({s_read, m0_waitrequest, pending} !== {2'b01, 4'd8}) begin
        n_fail++; $display("FAIL stall_cycle%0d: got rd=%b wr=%b p=%0d want 0 1 8", i, s_read, m0_waitrequest, pending);
      end
      tick;
    end
    m1_write = 1; m1_address = 25'h77; m1_writedata = 16'h5A5A; m1_byteenable = 2'b01;
    tick;
    n_checks++;
    if ({s_write, m1_waitrequest, m0_waitrequest, s_address} !== {3'b101, 25'h77}) begin
      n_fail++; $display("FAIL stall_write: got wr=%b waits=%b addr=%h want 1 01 77", s_write, {m1_waitrequest, m0_waitrequest}, s_address);
    end
    tick;
    m1_write = 0;
    s_readdatavalid = 1;
    #1;
    n_checks++;
    if ({m1_readdatavalid, m0_readdatavalid, s_read, pending} !== {3'b010, 4'd8}) begin
      n_fail++; $display("FAIL stall_pop: got rdv=%b rd=%b p=%0d want 01 0 8", {m1_readdatavalid, m0_readdatavalid}, s_read, pending);
    end
    tick;
    s_readdatavalid = 0;
    #1;
    n_checks++;
    if ({pending, s_read} !== {4'd7, 1'b0}) begin n_fail++; $display("FAIL stall_after_pop: got p=%0d rd=%b want 7 0", pending, s_read); end
    tick;
    n_checks++;
    if ({s_read, m0_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL stall_release: got %b want 10", {s_read, m0_waitrequest}); end
    s_readdatavalid = 1;
    #1;
    n_checks++;
    if ({m1_readdatavalid, m0_readdatavalid} !== 2'b01) begin n_fail++; $display("FAIL pushpop_route: got %b want 01", {m1_readdatavalid, m0_readdatavalid}); end
    tick;
    s_readdatavalid = 0; m0_read = 0;
    #1;
    n_checks++;
    if (pending !== 4'd7) begin n_fail++; $display("FAIL pushpop_count: got %0d want 7", pending); end
  endtask

  task automatic test_orphan;
    do_reset;
    m0_read = 1; m0_address = 25'h40;
    repeat (6) tick;
    m0_read = 0;
    #1;
    n_checks++;
    if (pending !== 4'd3) begin n_fail++; $display("FAIL orphan_setup: got %0d want 3", pending); end
    reset = 1;
    tick;
    reset = 0;
    #1;
    n_checks++;
    if ({pending, err_orphan, s_read} !== {4'd0, 2'b00}) begin
      n_fail++; $display("FAIL orphan_reset: got p=%0d orphan=%b rd=%b want 0 0 0", pending, err_orphan, s_read);
    end
    s_readdatavalid = 1; s_readdata = 16'hDEAD;
    #1;
    n_checks++;
    if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL orphan_route: got %b want 00", {m1_readdatavalid, m0_readdatavalid}); end
    tick;
    s_readdatavalid = 0;
    #1;
    n_checks++;
    if ({err_orphan, pending} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL orphan_flag: got orphan=%b p=%0d want 1 0", err_orphan, pending); end
    tick;
    n_checks++;
    if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_round_robin;
    test_hold;
    test_stall;
    test_orphan;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
